// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit field layout, flit type codes, one-hot output
// port encoding and the input-stage FSM state type.
package noc_pkg;

    localparam int COORD_W = 2;
    localparam int PORT_W  = 5;

    localparam int TYPE_MSB = 7;
    localparam int TYPE_LSB = 6;
    localparam int DX_MSB   = 3;
    localparam int DX_LSB   = 2;
    localparam int DY_MSB   = 1;
    localparam int DY_LSB   = 0;

    localparam logic [1:0] FLIT_BODY   = 2'b00;
    localparam logic [1:0] FLIT_HEAD   = 2'b01;
    localparam logic [1:0] FLIT_TAIL   = 2'b10;
    localparam logic [1:0] FLIT_SINGLE = 2'b11;

    localparam logic [PORT_W-1:0] PORT_L = 5'b00001;
    localparam logic [PORT_W-1:0] PORT_N = 5'b00010;
    localparam logic [PORT_W-1:0] PORT_E = 5'b00100;
    localparam logic [PORT_W-1:0] PORT_S = 5'b01000;
    localparam logic [PORT_W-1:0] PORT_W_ = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND
    } state_t;

endpackage

// File: rtl/noc_xy_route_calc.sv
// Dimension-ordered XY route decision: resolve X first, then Y, else Local.
// Purely combinational so every input port of the router can share the same block.
module noc_xy_route_calc
    import noc_pkg::*;
(
    input  logic [COORD_W-1:0] dest_x,
    input  logic [COORD_W-1:0] dest_y,
    input  logic [COORD_W-1:0] cur_x,
    input  logic [COORD_W-1:0] cur_y,
    output logic [PORT_W-1:0]  port
);

    always_comb begin
        if (dest_x > cur_x) begin
            port = PORT_E;
        end else if (dest_x < cur_x) begin
            port = PORT_W_;
        end else if (dest_y > cur_y) begin
            port = PORT_N;
        end else if (dest_y < cur_y) begin
            port = PORT_S;
        end else begin
            port = PORT_L;
        end
    end

endmodule

// File: rtl/noc_xy_route_unit.sv
// Router input-port stage: pops flits from the port FIFO, XY-routes each head
// flit, locks that port for the packet and hands flits to the crossbar on valid/ready.
module noc_xy_route_unit
    import noc_pkg::*;
#(
    parameter int FLIT_W = 8,
    parameter int CUR_X  = 0,
    parameter int CUR_Y  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_read,
    output logic [FLIT_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PORT_W-1:0] out_port,
    output logic              busy,
    output logic              err
);

    localparam logic [COORD_W-1:0] CUR_X_C = COORD_W'(CUR_X);
    localparam logic [COORD_W-1:0] CUR_Y_C = COORD_W'(CUR_Y);

    state_t              state_q;
    state_t              state_d;
    logic [FLIT_W-1:0]   flit_q;
    logic [PORT_W-1:0]   lock_q;
    logic                busy_q;
    logic                err_q;
    logic [PORT_W-1:0]   route;
    logic [1:0]          in_type;
    logic [1:0]          flit_type;
    logic                in_head;
    logic                flit_tail;

    assign in_type   = fifo_data[TYPE_MSB:TYPE_LSB];
    assign flit_type = flit_q[TYPE_MSB:TYPE_LSB];
    assign in_head   = (in_type == FLIT_HEAD) || (in_type == FLIT_SINGLE);
    assign flit_tail = (flit_type == FLIT_TAIL) || (flit_type == FLIT_SINGLE);

    noc_xy_route_calc u_route_calc (
        .dest_x (fifo_data[DX_MSB:DX_LSB]),
        .dest_y (fifo_data[DY_MSB:DY_LSB]),
        .cur_x  (CUR_X_C),
        .cur_y  (CUR_Y_C),
        .port   (route)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first, so every path assigns and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_FETCH;
            ST_FETCH: state_d = (in_head || busy_q) ? ST_SEND : ST_IDLE;
            ST_SEND:  if (out_ready) state_d = fifo_empty ? ST_IDLE : ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_read = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: fifo_read = !fifo_empty;
            ST_SEND: begin
                out_valid = 1'b1;
                fifo_read = out_ready && !fifo_empty;
            end
            default: ;
        endcase
    end

    // Flit register, route lock, packet-in-progress flag and error pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            flit_q <= '0;
            lock_q <= '0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_FETCH: begin
                    if (in_head) begin
                        flit_q <= fifo_data;
                        lock_q <= route;
                        busy_q <= 1'b1;
                        err_q  <= busy_q;   // head arriving inside a packet: tail was lost
                    end else if (busy_q) begin
                        flit_q <= fifo_data;
                    end else begin
                        err_q  <= 1'b1;     // body/tail with no open packet is dropped
                    end
                end
                ST_SEND: begin
                    if (out_ready && flit_tail) busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign out_data = flit_q;
    assign out_port = lock_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_noc_xy_route_unit.sv
// Directed bench for noc_xy_route_unit at router (1,1) with a behavioural FIFO
// that returns data the cycle after each read strobe.
module tb_noc_xy_route_unit;

    localparam logic [4:0] P_L = 5'b00001;
    localparam logic [4:0] P_E = 5'b00100;
    localparam logic [4:0] P_S = 5'b01000;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_empty;
    logic       fifo_read;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_port;
    logic       busy;
    logic       err;

    logic [7:0] mem [0:31];
    logic [4:0] wr_ptr = 5'd0;
    logic [4:0] rd_ptr = 5'd0;

    int checks = 0;
    int errors = 0;

    noc_xy_route_unit #(.FLIT_W(8), .CUR_X(1), .CUR_Y(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_read  (fifo_read),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_port   (out_port),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_read) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 5'd1;
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] f);
        mem[wr_ptr] = f;
        wr_ptr = wr_ptr + 5'd1;
    endtask

    task automatic expect_send(input string tag, input logic [7:0] d, input logic [4:0] p,
                               input logic b);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_data"}, out_data, d);
        check({tag, "_port"}, out_port, p);
        check({tag, "_busy"}, busy, b);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        check("rst_valid", out_valid, 1'b0);
        check("rst_data",  out_data,  8'h00);
        check("rst_port",  out_port,  5'b0);
        check("rst_busy",  busy,      1'b0);
        check("rst_err",   err,       1'b0);
        check("rst_read",  fifo_read, 1'b0);
        rst = 1'b1;
        tick();

        // Single-flit packet 0xC9 -> dest (2,1) -> East
        out_ready = 1'b1;
        push(8'hC9);
        #1 check("t1_read", fifo_read, 1'b1);
        tick();
        check("t1_read_once", fifo_read, 1'b0);
        check("t1_fetch_valid", out_valid, 1'b0);
        tick();
        expect_send("t1_send", 8'hC9, P_E, 1'b1);
        check("t1_err", err, 1'b0);
        check("t1_read_empty", fifo_read, 1'b0);
        tick();
        check("t1_done_valid", out_valid, 1'b0);
        check("t1_done_busy", busy, 1'b0);
        check("t1_done_err", err, 1'b0);

        // Three-flit packet to (1,0) -> South, one flit every 2 cycles
        push(8'h44); push(8'h2A); push(8'h95);
        #1 check("t2_read", fifo_read, 1'b1);
        tick();
        check("t2_f0_valid", out_valid, 1'b0);
        tick();
        expect_send("t2_head", 8'h44, P_S, 1'b1);
        check("t2_head_read", fifo_read, 1'b1);
        tick();
        check("t2_gap0_valid", out_valid, 1'b0);
        check("t2_gap0_busy", busy, 1'b1);
        tick();
        expect_send("t2_body", 8'h2A, P_S, 1'b1);
        check("t2_body_read", fifo_read, 1'b1);
        tick();
        check("t2_gap1_valid", out_valid, 1'b0);
        tick();
        expect_send("t2_tail", 8'h95, P_S, 1'b1);
        check("t2_tail_read", fifo_read, 1'b0);
        tick();
        check("t2_done_busy", busy, 1'b0);
        check("t2_done_valid", out_valid, 1'b0);
        check("t2_done_err", err, 1'b0);

        // Backpressure: 0x45 (Local head) then tail 0x80
        out_ready = 1'b0;
        push(8'h45); push(8'h80);
        #1 check("t3_read", fifo_read, 1'b1);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            expect_send("t3_hold", 8'h45, P_L, 1'b1);
            check("t3_hold_read", fifo_read, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        #1 check("t3_release_read", fifo_read, 1'b1);
        tick();
        check("t3_gap_valid", out_valid, 1'b0);
        tick();
        expect_send("t3_tail", 8'h80, P_L, 1'b1);
        tick();
        check("t3_done_busy", busy, 1'b0);

        // Orphan body flit 0x15 while no packet is open
        push(8'h15);
        #1 check("t4_read", fifo_read, 1'b1);
        tick();
        check("t4_err_early", err, 1'b0);
        check("t4_valid0", out_valid, 1'b0);
        tick();
        check("t4_err", err, 1'b1);
        check("t4_valid1", out_valid, 1'b0);
        check("t4_busy", busy, 1'b0);
        tick();
        check("t4_err_clear", err, 1'b0);
        check("t4_valid2", out_valid, 1'b0);

        // Missing tail: 0x44, 0x2A, then a new head 0x79 -> East, closed by tail 0x80
        push(8'h44); push(8'h2A); push(8'h79);
        #1 check("t5_read", fifo_read, 1'b1);
        tick();
        tick();
        expect_send("t5_head", 8'h44, P_S, 1'b1);
        tick();
        tick();
        expect_send("t5_body", 8'h2A, P_S, 1'b1);
        tick();
        check("t5_err_early", err, 1'b0);
        tick();
        expect_send("t5_relock", 8'h79, P_E, 1'b1);
        check("t5_err", err, 1'b1);
        push(8'h80);
        #1 check("t5_relock_read", fifo_read, 1'b1);
        tick();
        check("t5_err_clear", err, 1'b0);
        tick();
        expect_send("t5_tail", 8'h80, P_E, 1'b1);
        tick();
        check("t5_done_busy", busy, 1'b0);

        // Reset during SEND of 0x2A, then tail 0x95 arrives as an orphan
        push(8'h44); push(8'h2A);
        tick();
        tick();
        expect_send("t6_head", 8'h44, P_S, 1'b1);
        tick();
        tick();
        expect_send("t6_body", 8'h2A, P_S, 1'b1);
        rst = 1'b0;
        tick();
        check("t6_rst_valid", out_valid, 1'b0);
        check("t6_rst_busy",  busy,      1'b0);
        check("t6_rst_port",  out_port,  5'b0);
        check("t6_rst_data",  out_data,  8'h00);
        rst = 1'b1;
        push(8'h95);
        #1 check("t6_read", fifo_read, 1'b1);
        tick();
        check("t6_orphan_valid0", out_valid, 1'b0);
        tick();
        check("t6_orphan_err", err, 1'b1);
        check("t6_orphan_valid1", out_valid, 1'b0);
        check("t6_orphan_busy", busy, 1'b0);
        tick();
        check("t6_orphan_err_clear", err, 1'b0);
        check("t6_orphan_valid2", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
